rr_mux_arbiter: RTL

- Four-requester round-robin arbiter that shares a WIDTH-bit 4:1 MUX datapath onto one registered output channel.
- Selects a winning requester, steers its data through the MUX select and captures it into a one-entry output buffer.
- The downstream side uses a valid/ready handshake.
- Sits between lab requesters (ALU operand sources, test stimulus) and a single consumer. Sel is exported so an external 4:1 MUX can be driven in lockstep.

---
 rtl/rr_mux_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/rr_mux_arbiter.sv
// Four-requester round-robin arbiter that steers the winning requester's data
// through a 4:1 MUX into a one-entry registered output slot with a valid/ready drain.
module rr_mux_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       Req,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic [WIDTH-1:0] D3,
  output logic [3:0]       Gnt,
  output logic [1:0]       Sel,
  output logic [WIDTH-1:0] Y,
  output logic             YValid,
  input  logic             YReady,
  output logic             Busy,
  output logic [CNT_W-1:0] GrantCount
);

  // Handshake: a word moves to the consumer on a rising edge where YValid=1 and
  // YReady=1; a requester's word moves into the slot on an edge where Gnt[k]=1.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_t;

  slot_t            r_slot;
  slot_t            w_slot_nxt;
  logic [1:0]       r_ptr;
  logic [1:0]       r_last_sel;
  logic [WIDTH-1:0] r_y;
  logic [CNT_W-1:0] r_grant_count;

  logic             w_any_req;
  logic [1:0]       w_winner;
  logic             w_found;
  logic             w_accept;
  logic             w_pop;
  logic [WIDTH-1:0] w_mux_data;

  assign w_any_req = |Req;

  // Rotating priority scan starting at r_ptr.
  always_comb begin
    logic [1:0] idx;
    w_winner = r_ptr;
    w_found  = 1'b0;
    idx      = r_ptr;
    for (int i = 0; i < 4; i++) begin
      idx = r_ptr + 2'(i);
      if (!w_found && Req[idx]) begin
        w_winner = idx;
        w_found  = 1'b1;
      end
    end
  end

  assign w_pop    = (r_slot == SLOT_FULL) && YReady;
  // No grant can be issued while reset is held, even though Req may be active.
  assign w_accept = !rst && w_any_req && ((r_slot == SLOT_EMPTY) || YReady);

  always_comb begin
    Gnt = 4'b0000;
    if (w_accept) begin
      Gnt[w_winner] = 1'b1;
    end
  end

  assign Sel = (w_any_req && !rst) ? w_winner : r_last_sel;

  always_comb begin
    w_mux_data = D0;
    case (Sel)
      2'd0:    w_mux_data = D0;
      2'd1:    w_mux_data = D1;
      2'd2:    w_mux_data = D2;
      default: w_mux_data = D3;
    endcase
  end

  always_comb begin
    w_slot_nxt = r_slot;
    if (w_accept) begin
      w_slot_nxt = SLOT_FULL;
    end else if (w_pop) begin
      w_slot_nxt = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot <= SLOT_EMPTY;
    end else begin
      r_slot <= w_slot_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y           <= '0;
      r_ptr         <= 2'd0;
      r_last_sel    <= 2'd0;
      r_grant_count <= '0;
    end else if (w_accept) begin
      r_y           <= w_mux_data;
      r_ptr         <= w_winner + 2'd1;
      r_last_sel    <= w_winner;
      r_grant_count <= r_grant_count + 1'b1;
    end
  end

  assign Y          = r_y;
  assign YValid     = (r_slot == SLOT_FULL);
  assign Busy       = YValid;
  assign GrantCount = r_grant_count;

endmodule
